// File: rtl/instr_encoder_if.sv
// Request/response bus for instr_encoder: a valid/ready mnemonic+operand
// request stream in, a valid/ready encoded RV32I word stream out.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder (mnemonic index + operands -> 32-bit word).
// Define ENC_RANGE_CHECK_EN to also flag out-of-range immediates on out_err.
module instr_encoder (
    input  logic           clk,
    input  logic           reset,
    instr_encoder_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SHIFT, FMT_S, FMT_B, FMT_J, FMT_U, FMT_ILLEGAL
    } fmt_t;

    logic        s1_valid;
    logic [5:0]  s1_op;
    logic [4:0]  s1_rd;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [31:0] s1_imm;

    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic        out_err_q;
    logic [15:0] enc_count_q;

    logic        advance;
    logic        in_ready_int;
    logic        accept;

    fmt_t        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        range_err;

    // Stage 1 may move on whenever the output register is empty or being drained.
    assign advance      = !out_valid_q || bus.out_ready;
    assign in_ready_int = !reset && (!s1_valid || advance);
    assign accept       = bus.in_valid && in_ready_int;

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_err   = out_err_q;
    assign bus.enc_count = enc_count_q;

    always_comb begin
        fmt    = FMT_ILLEGAL;
        opcode = 7'h13;
        funct3 = 3'h0;
        funct7 = 7'h00;
        case (s1_op)
            6'd0:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h0; end
            6'd1:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h0; funct7 = 7'h20; end
            6'd2:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h4; end
            6'd3:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h6; end
            6'd4:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h7; end
            6'd5:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h1; end
            6'd6:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h5; end
            6'd7:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h5; funct7 = 7'h20; end
            6'd8:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h2; end
            6'd9:  begin fmt = FMT_R;     opcode = 7'h33; funct3 = 3'h3; end
            6'd10: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h0; end
            6'd11: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h4; end
            6'd12: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h6; end
            6'd13: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h7; end
            6'd14: begin fmt = FMT_SHIFT; opcode = 7'h13; funct3 = 3'h1; end
            6'd15: begin fmt = FMT_SHIFT; opcode = 7'h13; funct3 = 3'h5; end
            6'd16: begin fmt = FMT_SHIFT; opcode = 7'h13; funct3 = 3'h5; funct7 = 7'h20; end
            6'd17: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h2; end
            6'd18: begin fmt = FMT_I;     opcode = 7'h13; funct3 = 3'h3; end
            6'd19: begin fmt = FMT_I;     opcode = 7'h03; funct3 = 3'h0; end
            6'd20: begin fmt = FMT_I;     opcode = 7'h03; funct3 = 3'h1; end
            6'd21: begin fmt = FMT_I;     opcode = 7'h03; funct3 = 3'h2; end
            6'd22: begin fmt = FMT_I;     opcode = 7'h03; funct3 = 3'h4; end
            6'd23: begin fmt = FMT_I;     opcode = 7'h03; funct3 = 3'h5; end
            6'd24: begin fmt = FMT_S;     opcode = 7'h23; funct3 = 3'h0; end
            6'd25: begin fmt = FMT_S;     opcode = 7'h23; funct3 = 3'h1; end
            6'd26: begin fmt = FMT_S;     opcode = 7'h23; funct3 = 3'h2; end
            6'd27: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h0; end
            6'd28: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h1; end
            6'd29: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h4; end
            6'd30: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h5; end
            6'd31: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h6; end
            6'd32: begin fmt = FMT_B;     opcode = 7'h63; funct3 = 3'h7; end
            6'd33: begin fmt = FMT_J;     opcode = 7'h6F; end
            6'd34: begin fmt = FMT_I;     opcode = 7'h67; funct3 = 3'h0; end
            6'd35: begin fmt = FMT_U;     opcode = 7'h37; end
            6'd36: begin fmt = FMT_U;     opcode = 7'h17; end
            default: fmt = FMT_ILLEGAL;
        endcase
    end

`ifdef ENC_RANGE_CHECK_EN
    // The word is still built from truncated fields; this only raises the flag.
    always_comb begin
        range_err = 1'b0;
        case (fmt)
            FMT_I, FMT_S: range_err = ($signed(s1_imm) < -2048) || ($signed(s1_imm) > 2047);
            FMT_SHIFT:    range_err = (s1_imm > 32'd31);
            FMT_B:        range_err = ($signed(s1_imm) < -4096) || ($signed(s1_imm) > 4094) || s1_imm[0];
            FMT_J:        range_err = ($signed(s1_imm) < -1048576) || ($signed(s1_imm) > 1048574) || s1_imm[0];
            FMT_U:        range_err = (s1_imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    always_comb begin
        enc_word = 32'h0000_0013;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R:     enc_word = {funct7, s1_rs2, s1_rs1, funct3, s1_rd, opcode};
            FMT_I:     enc_word = {s1_imm[11:0], s1_rs1, funct3, s1_rd, opcode};
            FMT_SHIFT: enc_word = {funct7, s1_imm[4:0], s1_rs1, funct3, s1_rd, opcode};
            FMT_S:     enc_word = {s1_imm[11:5], s1_rs2, s1_rs1, funct3, s1_imm[4:0], opcode};
            FMT_B:     enc_word = {s1_imm[12], s1_imm[10:5], s1_rs2, s1_rs1, funct3,
                                   s1_imm[4:1], s1_imm[11], opcode};
            FMT_J:     enc_word = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12],
                                   s1_rd, opcode};
            FMT_U:     enc_word = {s1_imm[31:12], s1_rd, opcode};
            default: begin
                enc_word = 32'h0000_0013;
                enc_err  = 1'b1;
            end
        endcase
        enc_err = enc_err | range_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (in_ready_int) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op  <= bus.in_op;
            s1_rd  <= bus.in_rd;
            s1_rs1 <= bus.in_rs1;
            s1_rs2 <= bus.in_rs2;
            s1_imm <= bus.in_imm;
        end
    end

    // The output word only changes when it is being consumed or the slot is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0;
            out_err_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                out_instr_q <= enc_word;
                out_err_q   <= enc_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_count_q <= 16'h0;
        end else if (out_valid_q && bus.out_ready) begin
            enc_count_q <= enc_count_q + 16'd1;
        end
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL expose the following ports (name, direction, width, meaning):
  clk  input  1  rising-edge clock
  reset  input  1  reset, synchronous, active-high
  in_valid  input  1  request present
  in_ready  output  1  block can accept a request this cycle
  in_op  input  6  mnemonic index (REQ-007)
  in_rd  input  5  destination register
  in_rs1  input  5  source register 1
  in_rs2  input  5  source register 2
  in_imm  input  32  signed immediate, byte offset for B/J; for U, full value with the upper 20 bits used
  out_valid  output  1  encoded word present
  out_ready  input  1  consumer accepts the word
  out_instr  output  32  encoded RV32I instruction
  out_err  output  1  illegal op or immediate out of range
  enc_count  output  16  count of completed output handshakes
REQ-002 The block SHALL have no parameters.

Function
REQ-003 The block SHALL accept a request only on a cycle where in_valid=1 and in_ready=1.
REQ-004 The block SHALL be a two-stage pipeline: stage 1 registers the request fields, and stage 2 registers the encoded out_instr and out_err.
REQ-005 With out_ready held at 1, out_valid SHALL rise 2 cycles after acceptance, and throughput SHALL be 1 word per cycle.
REQ-006 Backpressure and stalling SHALL follow these rules:
  in_ready = !s1_valid || s1 advancing; s1 advances when !out_valid || out_ready.
  While out_valid=1 and out_ready=0, out_instr and out_err SHALL hold stable.
  No request SHALL be dropped, duplicated or reordered.
REQ-007 in_op SHALL map to mnemonics as follows:
  0-9: ADD, SUB, XOR, OR, AND, SLL, SRL, SRA, SLT, SLTU
  10-18: ADDI, XORI, ORI, ANDI, SLLI, SRLI, SRAI, SLTI, SLTIU
  19-23: LB, LH, LW, LBU, LHU
  24-26: SB, SH, SW
  27-32: BEQ, BNE, BLT, BGE, BLTU, BGEU
  33: JAL; 34: JALR; 35: LUI; 36: AUIPC
REQ-008 Encoding SHALL use standard RV32I opcode, funct3 and funct7 values, with these details:
  SUB and SRA SHALL set funct7=0x20.
  SRAI SHALL place 0x20 in bits 31:25 and in_imm[4:0] in bits 24:20.
REQ-009 Immediates SHALL be placed as follows:
  I: in_imm[11:0] to bits 31:20.
  S: in_imm[11:5] to bits 31:25 and in_imm[4:0] to bits 11:7.
  B: imm[12|10:5] to bits 31:25 and imm[4:1|11] to bits 11:7.
  J: imm[20|10:1|11|19:12] to bits 31:12.
  U: in_imm[31:12] to bits 31:12.
REQ-010 Register fields that are unused by a format SHALL encode as 0.
REQ-011 For in_op >= 37, the block SHALL output out_instr=0x00000013 (NOP) with out_err=1.
REQ-012 enc_count SHALL increment on each out_valid && out_ready cycle and SHALL wrap from 0xFFFF to 0x0000.
REQ-013 If in_valid and a stall occur in the same cycle, the stall SHALL take priority, in_ready=0, and the request SHALL be held by the source.

Reset
REQ-014 While reset=1 at a clock edge, the block SHALL clear s1_valid and out_valid, and set out_instr=0, out_err=0 and enc_count=0.
REQ-015 in_ready SHALL be 0 while reset=1.
REQ-016 Requests in flight when reset is asserted SHALL be discarded with no output handshake.
REQ-017 in_ready SHALL be 1 on the first cycle after reset is released.

Configuration
REQ-018 With ENC_RANGE_CHECK_EN defined, out_err SHALL also be set when the immediate is out of range for its format:
  I/S: outside -2048..2047.
  Shifts: outside 0..31.
  B: outside -4096..4094 or odd.
  J: outside -1048576..1048574 or odd.
  U: in_imm[11:0] != 0.
  The word SHALL still be encoded from the truncated fields.
REQ-019 Without ENC_RANGE_CHECK_EN, out_err SHALL flag only an illegal in_op, and immediates SHALL be truncated silently.

Verification
REQ-020 ADDI, rd=1, rs1=0, imm=5, with out_ready=1 -> out_instr=0x00500093, out_err=0, out_valid 2 cycles after acceptance.
REQ-021 ADD x3,x1,x2 then SUB x3,x1,x2 on back-to-back cycles -> 0x002081B3 then 0x402081B3 on consecutive cycles; enc_count goes 0 -> 2.
REQ-022 BEQ, rs1=1, rs2=2, imm=8 -> 0x00208463; in_op=63 -> 0x00000013 with out_err=1.
REQ-023 Backpressure: three requests with out_ready=0 for 4 cycles -> in_ready=0 once both stages are full, out_instr is stable, and all three words emerge in order after out_ready=1.
REQ-024 ADDI, rd=1, imm=4096 -> out_instr=0x00000093; out_err=1 with ENC_RANGE_CHECK_EN and 0 without it.
REQ-025 Reset asserted with two words in flight -> out_valid=0 and enc_count=0 the next cycle, and no stale word appears afterwards.
